dec_mpp: RTL and testbench

- MPP (midpoint-prediction) reconstruction stage of the VDC-M block decoder.
- Takes the per-substream quantized MPP residuals of one 8x2 block from the four substream parsers (ssm0 pre-aligned by one register in the parent) and de-interleaves them into 3 components x 16 samples.
- Dequantizes each residual, adds a per-component midpoint and clips to pixel range.
- Fully pipelined: accepts one block per clock while blk_vld is high.

---
 rtl/dec_mpp_pkg.sv | 28 ++
 rtl/dec_mpp_if.sv | 22 ++
 rtl/mpp_comp_recon.sv | 36 +++
 rtl/dec_mpp.sv | 65 ++++++
 tb/tb_dec_mpp.sv | 226 ++++++++++++++++++++++
 5 files changed

// File: rtl/dec_mpp_pkg.sv
// dec_mpp_pkg: shared constants, types and helpers for the MPP reconstruction stage
package dec_mpp_pkg;
  localparam int BIT_DEPTH = 8;
  localparam int QRES_W = 8;
  localparam int NUM_SAMP = 16;
  localparam int SLOTS_USED = 12;
  localparam int NUM_COMP = 3;
  localparam int NUM_SSM = 4;
  localparam int DEQ_W = QRES_W + BIT_DEPTH + 1;
  localparam int SUM_W = BIT_DEPTH + 5;
  localparam int STEP_W = $clog2(BIT_DEPTH);
  localparam logic signed [DEQ_W-1:0] PIX_MAX = DEQ_W'((1 << BIT_DEPTH) - 1);
  typedef logic [BIT_DEPTH-1:0] pix_t;
  typedef logic signed [QRES_W-1:0] qres_t;
  typedef logic [STEP_W-1:0] step_t;
  typedef struct packed {
    logic [1:0] comp;
    logic [$clog2(NUM_SAMP)-1:0] samp;
  } loc_t;
  function automatic loc_t map_slot(input int ssm, input int slot);
    int k;
    k = ssm * SLOTS_USED + slot;
    return '{comp: 2'(k / NUM_SAMP), samp: $clog2(NUM_SAMP)'(k % NUM_SAMP)};
  endfunction
  function automatic pix_t clip_pix(input logic signed [DEQ_W-1:0] v);
    return v[DEQ_W-1] ? '0 : (v > PIX_MAX) ? '1 : v[BIT_DEPTH-1:0];
  endfunction
endpackage

// File: rtl/dec_mpp_if.sv
// dec_mpp_if: residual-in / recon-out bundle of the MPP reconstruction stage
interface dec_mpp_if;
  import dec_mpp_pkg::*;
  logic blk_vld;
  qres_t mpp_qres_ssm0 [NUM_SAMP];
  qres_t mpp_qres_ssm1 [NUM_SAMP];
  qres_t mpp_qres_ssm2 [NUM_SAMP];
  qres_t mpp_qres_ssm3 [NUM_SAMP];
  logic [3:0] mpp_stepsize;
  logic recon_vld;
  pix_t recon_c0 [NUM_SAMP];
  pix_t recon_c1 [NUM_SAMP];
  pix_t recon_c2 [NUM_SAMP];
  modport master (
    output blk_vld, mpp_qres_ssm0, mpp_qres_ssm1, mpp_qres_ssm2, mpp_qres_ssm3, mpp_stepsize,
    input recon_vld, recon_c0, recon_c1, recon_c2
  );
  modport slave (
    input blk_vld, mpp_qres_ssm0, mpp_qres_ssm1, mpp_qres_ssm2, mpp_qres_ssm3, mpp_stepsize,
    output recon_vld, recon_c0, recon_c1, recon_c2
  );
endinterface

// File: rtl/mpp_comp_recon.sv
// mpp_comp_recon: 16-lane dequant/add/clip for one component, owning its running midpoint
module mpp_comp_recon
  import dec_mpp_pkg::*;
(
  input  logic  clk,
  input  logic  rstn,
  input  logic  vld_i,
  input  step_t step_i,
  input  qres_t qres_i [NUM_SAMP],
  output pix_t  recon_o [NUM_SAMP]
);
  localparam pix_t MP_RST = pix_t'(1 << (BIT_DEPTH - 1));
  pix_t mp_q, mp_d;
  pix_t recon_d [NUM_SAMP];
  pix_t recon_q [NUM_SAMP];
  logic [SUM_W-1:0] sum;
  always_comb begin
    sum = '0;
    recon_d = '{default: '0};
    for (int i = 0; i < NUM_SAMP; i++) begin
      recon_d[i] = clip_pix((DEQ_W'(qres_i[i]) <<< step_i) + $signed(DEQ_W'(mp_q)));
      sum = sum + SUM_W'(recon_d[i]);
    end
    mp_d = pix_t'((sum + SUM_W'(NUM_SAMP / 2)) >> $clog2(NUM_SAMP));
  end
  always_ff @(posedge clk) begin
    if (!rstn) begin
      mp_q <= MP_RST;
      recon_q <= '{default: '0};
    end else if (vld_i) begin
      mp_q <= mp_d;
      recon_q <= recon_d;
    end
  end
  assign recon_o = recon_q;
endmodule

// File: rtl/dec_mpp.sv
// dec_mpp: de-interleaves the four substreams' MPP residuals of an 8x2 block into
// three components and reconstructs them around a per-component running midpoint.
module dec_mpp
  import dec_mpp_pkg::*;
(
  input logic      clk,
  input logic      rstn,
  dec_mpp_if.slave bus
);
  qres_t ssm [NUM_SSM][NUM_SAMP];
  qres_t qres_d [NUM_COMP][NUM_SAMP];
  qres_t qres_q [NUM_COMP][NUM_SAMP];
  pix_t recon [NUM_COMP][NUM_SAMP];
  step_t step_d, step_q;
  logic vld_q, recon_vld_q;
  logic unused_slots;
  loc_t m;
  assign ssm[0] = bus.mpp_qres_ssm0;
  assign ssm[1] = bus.mpp_qres_ssm1;
  assign ssm[2] = bus.mpp_qres_ssm2;
  assign ssm[3] = bus.mpp_qres_ssm3;
  assign step_d = (bus.mpp_stepsize > 4'(BIT_DEPTH - 1)) ? step_t'(BIT_DEPTH - 1) : step_t'(bus.mpp_stepsize);
  // slots past SLOTS_USED carry no MPP data for this block
  always_comb begin
    qres_d = '{default: '0};
    unused_slots = 1'b0;
    m = '0;
    for (int s = 0; s < NUM_SSM; s++) begin
      for (int j = 0; j < SLOTS_USED; j++) begin
        m = map_slot(s, j);
        qres_d[m.comp][m.samp] = ssm[s][j];
      end
      for (int j = SLOTS_USED; j < NUM_SAMP; j++) unused_slots = unused_slots ^ (^ssm[s][j]);
    end
  end
  always_ff @(posedge clk) begin
    if (!rstn) begin
      vld_q <= 1'b0;
      recon_vld_q <= 1'b0;
      step_q <= '0;
      qres_q <= '{default: '0};
    end else begin
      vld_q <= bus.blk_vld;
      recon_vld_q <= vld_q;
      if (bus.blk_vld) begin
        qres_q <= qres_d;
        step_q <= step_d;
      end
    end
  end
  for (genvar c = 0; c < NUM_COMP; c++) begin : g_comp
    mpp_comp_recon u_recon (
      .clk     (clk),
      .rstn    (rstn),
      .vld_i   (vld_q),
      .step_i  (step_q),
      .qres_i  (qres_q[c]),
      .recon_o (recon[c])
    );
  end
  assign bus.recon_vld = recon_vld_q;
  assign bus.recon_c0 = recon[0];
  assign bus.recon_c1 = recon[1];
  assign bus.recon_c2 = recon[2];
endmodule

// File: tb/tb_dec_mpp.sv
// tb_dec_mpp: directed scenarios for the MPP reconstruction stage
module tb_dec_mpp;
  import dec_mpp_pkg::*;
  logic clk, rstn;
  int errors = 0;
  int checks = 0;
  qres_t ss [NUM_SSM][NUM_SAMP];
  pix_t exp_v [NUM_COMP][NUM_SAMP];
  pix_t got [NUM_COMP][NUM_SAMP];
  dec_mpp_if bus ();
  dec_mpp dut (.clk(clk), .rstn(rstn), .bus(bus));
  assign bus.mpp_qres_ssm0 = ss[0];
  assign bus.mpp_qres_ssm1 = ss[1];
  assign bus.mpp_qres_ssm2 = ss[2];
  assign bus.mpp_qres_ssm3 = ss[3];
  assign got[0] = bus.recon_c0;
  assign got[1] = bus.recon_c1;
  assign got[2] = bus.recon_c2;
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic clr_in();
    bus.blk_vld = 1'b0;
    bus.mpp_stepsize = 4'd0;
    for (int s = 0; s < NUM_SSM; s++) for (int i = 0; i < NUM_SAMP; i++) ss[s][i] = '0;
  endtask
  task automatic fill_exp(input pix_t v);
    for (int c = 0; c < NUM_COMP; c++) for (int i = 0; i < NUM_SAMP; i++) exp_v[c][i] = v;
  endtask
  task automatic do_reset();
    rstn = 1'b0;
    clr_in();
    step();
    rstn = 1'b1;
  endtask
  task automatic send_block();
    bus.blk_vld = 1'b1;
    step();
    bus.blk_vld = 1'b0;
    step();
  endtask
  task automatic test_reset();
    rstn = 1'b0;
    bus.blk_vld = 1'b1;
    bus.mpp_stepsize = 4'($urandom_range(0, 15));
    for (int s = 0; s < NUM_SSM; s++) for (int i = 0; i < NUM_SAMP; i++) ss[s][i] = qres_t'($urandom_range(0, 255));
    step();
    step();
    checks++;
    if (bus.recon_vld !== 1'b0) begin errors++; $display("FAIL reset_vld: got %0b expected 0", bus.recon_vld); end
    fill_exp(0);
    for (int c = 0; c < NUM_COMP; c++) for (int i = 0; i < NUM_SAMP; i++) begin
      checks++;
      if (got[c][i] !== exp_v[c][i]) begin errors++; $display("FAIL reset_val c%0d[%0d]: got %0d expected %0d", c, i, got[c][i], exp_v[c][i]); end
    end
    rstn = 1'b1;
    clr_in();
    bus.blk_vld = 1'b1;
    step();
    bus.blk_vld = 1'b0;
    checks++;
    if (bus.recon_vld !== 1'b0) begin errors++; $display("FAIL latency_early: got %0b expected 0", bus.recon_vld); end
    step();
    checks++;
    if (bus.recon_vld !== 1'b1) begin errors++; $display("FAIL latency_vld: got %0b expected 1", bus.recon_vld); end
    fill_exp(128);
    for (int c = 0; c < NUM_COMP; c++) for (int i = 0; i < NUM_SAMP; i++) begin
      checks++;
      if (got[c][i] !== exp_v[c][i]) begin errors++; $display("FAIL first_block c%0d[%0d]: got %0d expected %0d", c, i, got[c][i], exp_v[c][i]); end
    end
  endtask
  task automatic test_dequant();
    do_reset();
    ss[0][0] = 8'sh05;
    bus.mpp_stepsize = 4'd2;
    send_block();
    checks++;
    if (bus.recon_vld !== 1'b1) begin errors++; $display("FAIL dequant_vld: got %0b expected 1", bus.recon_vld); end
    fill_exp(128);
    exp_v[0][0] = 148;
    for (int c = 0; c < NUM_COMP; c++) for (int i = 0; i < NUM_SAMP; i++) begin
      checks++;
      if (got[c][i] !== exp_v[c][i]) begin errors++; $display("FAIL dequant c%0d[%0d]: got %0d expected %0d", c, i, got[c][i], exp_v[c][i]); end
    end
  endtask
  task automatic test_clip();
    logic [3:0] st [4] = '{4'd3, 4'd15, 4'd14, 4'd6};
    qres_t q1 [4] = '{8'sh7F, 8'sh01, 8'sh01, 8'sh01};
    qres_t q2 [4] = '{8'sh80, 8'shFF, 8'shFF, 8'shFF};
    pix_t e1 [4] = '{255, 255, 255, 192};
    pix_t e2 [4] = '{0, 0, 0, 64};
    for (int t = 0; t < 4; t++) begin
      do_reset();
      ss[0][1] = q1[t];
      ss[0][2] = q2[t];
      bus.mpp_stepsize = st[t];
      send_block();
      fill_exp(128);
      exp_v[0][1] = e1[t];
      exp_v[0][2] = e2[t];
      for (int c = 0; c < NUM_COMP; c++) for (int i = 0; i < NUM_SAMP; i++) begin
        checks++;
        if (got[c][i] !== exp_v[c][i]) begin errors++; $display("FAIL clip step%0d c%0d[%0d]: got %0d expected %0d", st[t], c, i, got[c][i], exp_v[c][i]); end
      end
    end
  endtask
  task automatic test_mapping();
    do_reset();
    ss[1][0] = 8'sd1;
    ss[1][4] = 8'sd1;
    ss[3][11] = 8'sd1;
    ss[0][11] = 8'sd2;
    ss[2][0] = 8'sd3;
    ss[2][8] = 8'sd1;
    for (int j = SLOTS_USED; j < NUM_SAMP; j++) ss[2][j] = 8'sh7F;
    send_block();
    fill_exp(128);
    exp_v[0][12] = 129;
    exp_v[1][0] = 129;
    exp_v[2][15] = 129;
    exp_v[0][11] = 130;
    exp_v[1][8] = 131;
    exp_v[2][0] = 129;
    for (int c = 0; c < NUM_COMP; c++) for (int i = 0; i < NUM_SAMP; i++) begin
      checks++;
      if (got[c][i] !== exp_v[c][i]) begin errors++; $display("FAIL mapping c%0d[%0d]: got %0d expected %0d", c, i, got[c][i], exp_v[c][i]); end
    end
  endtask
  task automatic test_midpoint();
    do_reset();
    for (int j = 0; j < SLOTS_USED; j++) ss[0][j] = 8'sh14;
    for (int j = 0; j < 4; j++) ss[1][j] = 8'sh14;
    bus.blk_vld = 1'b1;
    step();
    clr_in();
    bus.blk_vld = 1'b1;
    step();
    bus.blk_vld = 1'b0;
    fill_exp(128);
    for (int i = 0; i < NUM_SAMP; i++) exp_v[0][i] = 148;
    for (int b = 0; b < 2; b++) begin
      checks++;
      if (bus.recon_vld !== 1'b1) begin errors++; $display("FAIL b2b_vld blk%0d: got %0b expected 1", b, bus.recon_vld); end
      for (int c = 0; c < NUM_COMP; c++) for (int i = 0; i < NUM_SAMP; i++) begin
        checks++;
        if (got[c][i] !== exp_v[c][i]) begin errors++; $display("FAIL b2b blk%0d c%0d[%0d]: got %0d expected %0d", b, c, i, got[c][i], exp_v[c][i]); end
      end
      step();
    end
    for (int g = 0; g < 2; g++) begin
      checks++;
      if (bus.recon_vld !== 1'b0 || got[0][0] !== 8'd148) begin
        errors++; $display("FAIL bubble cyc%0d: got vld=%0b c0[0]=%0d expected vld=0 c0[0]=148", g, bus.recon_vld, got[0][0]);
      end
      step();
    end
    send_block();
    checks++;
    if (bus.recon_vld !== 1'b1) begin errors++; $display("FAIL gap_vld: got %0b expected 1", bus.recon_vld); end
    for (int c = 0; c < NUM_COMP; c++) for (int i = 0; i < NUM_SAMP; i++) begin
      checks++;
      if (got[c][i] !== exp_v[c][i]) begin errors++; $display("FAIL gap c%0d[%0d]: got %0d expected %0d", c, i, got[c][i], exp_v[c][i]); end
    end
    for (int j = 4; j < SLOTS_USED; j++) ss[1][j] = 8'sd1;
    bus.blk_vld = 1'b1;
    step();
    clr_in();
    bus.blk_vld = 1'b1;
    step();
    bus.blk_vld = 1'b0;
    for (int i = 0; i < 8; i++) exp_v[1][i] = 129;
    for (int b = 0; b < 2; b++) begin
      for (int c = 0; c < NUM_COMP; c++) for (int i = 0; i < NUM_SAMP; i++) begin
        checks++;
        if (got[c][i] !== exp_v[c][i]) begin errors++; $display("FAIL round blk%0d c%0d[%0d]: got %0d expected %0d", b, c, i, got[c][i], exp_v[c][i]); end
      end
      for (int i = 8; i < NUM_SAMP; i++) exp_v[1][i] = 129;
      step();
    end
  endtask
  task automatic test_reset_midstream();
    do_reset();
    for (int j = 0; j < SLOTS_USED; j++) ss[0][j] = 8'sh14;
    send_block();
    ss[0][0] = 8'sh10;
    bus.blk_vld = 1'b1;
    step();
    ss[0][1] = 8'sh10;
    rstn = 1'b0;
    step();
    checks++;
    if (bus.recon_vld !== 1'b0 || got[0][0] !== 8'd0) begin
      errors++; $display("FAIL midrst_hold: got vld=%0b c0[0]=%0d expected vld=0 c0[0]=0", bus.recon_vld, got[0][0]);
    end
    rstn = 1'b1;
    clr_in();
    step();
    checks++;
    if (bus.recon_vld !== 1'b0) begin errors++; $display("FAIL midrst_discard: got %0b expected 0", bus.recon_vld); end
    send_block();
    checks++;
    if (bus.recon_vld !== 1'b1) begin errors++; $display("FAIL midrst_vld: got %0b expected 1", bus.recon_vld); end
    fill_exp(128);
    for (int c = 0; c < NUM_COMP; c++) for (int i = 0; i < NUM_SAMP; i++) begin
      checks++;
      if (got[c][i] !== exp_v[c][i]) begin errors++; $display("FAIL midrst c%0d[%0d]: got %0d expected %0d", c, i, got[c][i], exp_v[c][i]); end
    end
  endtask
  initial begin
    rstn = 1'b0;
    clr_in();
    test_reset();
    test_dequant();
    test_clip();
    test_mapping();
    test_midpoint();
    test_reset_midstream();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
